shiftadd_seq: RTL and testbench

- Operand sequencer and result collector placed directly around the shiftadd multiplier.
- Buffers incoming (a, b) operand pairs in a small FIFO and issues one job at a time over shiftadd's start/a/b/flag/mul interface.
- Captures each product and presents it downstream through a valid/ready handshake.
- Guards each job with a timeout so a stuck multiplier cannot hang the pipe.

---
 rtl/shiftadd_pkg.sv | 23 ++
 rtl/shiftadd_fifo.sv | 69 ++++++
 rtl/shiftadd_seq.sv | 185 ++++++++++++++++++
 tb/tb_shiftadd_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shiftadd_pkg.sv
// Shared types and default sizing for the shiftadd operand sequencer.
package shiftadd_pkg;

    // Default operand width, FIFO depth and WAIT-state timeout.
    localparam int DEF_WIDTH   = 4;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 32;

    // Job sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Operand pair at the default width.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
    } operand_pair_t;

endpackage

// File: rtl/shiftadd_fifo.sv
// Synchronous FIFO with occupancy count, full and empty flags.
// Pushes when full and pops when empty are ignored; there is no bypass.
module shiftadd_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [DW-1:0]                i_data,
    input  logic                         i_pop,
    output logic [DW-1:0]                o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage write on an accepted push.
    // NOTE: the data array has no reset; occupancy is tracked by the count and
    // pointers, so stale entries are never read, and leaving it unreset keeps
    // it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: every sequential assignment uses <= so all registers update from
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/shiftadd_seq.sv
// Operand sequencer and result collector wrapped around the shiftadd
// multiplier: queues (a, b) pairs, runs one job at a time, returns each
// product through a valid/ready port and aborts jobs that never finish.
module shiftadd_seq
    import shiftadd_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_a,
    input  logic [WIDTH-1:0]            in_b,
    output logic [$clog2(DEPTH+1)-1:0]  fifo_count,
    output logic                        mul_start,
    output logic [WIDTH-1:0]            mul_a,
    output logic [WIDTH-1:0]            mul_b,
    input  logic                        mul_flag,
    input  logic [2*WIDTH-1:0]          mul_p,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [WIDTH-1:0]            res_a,
    output logic [WIDTH-1:0]            res_b,
    output logic [2*WIDTH-1:0]          res_p,
    output logic                        res_err
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    seq_state_t         r_state;
    seq_state_t         w_next_state;

    pair_t              w_fifo_in;
    pair_t              w_fifo_out;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_push;
    logic               w_pop;

    logic               w_load_ok;
    logic               w_load_err;

    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [TW-1:0]      r_tmo_cnt;

    logic [WIDTH-1:0]   r_res_a;
    logic [WIDTH-1:0]   r_res_b;
    logic [2*WIDTH-1:0] r_res_p;
    logic               r_res_err;

    // Ready comes from the registered count only, so a same-cycle pop never
    // opens a slot for a push.
    assign in_ready    = !w_fifo_full;
    assign w_push      = in_valid && in_ready;
    assign w_fifo_in   = '{a: in_a, b: in_b};

    shiftadd_fifo #(
        .DW    (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_fifo_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_out),
        .o_count (fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Multiplier drive: start is held through ISSUE and WAIT with stable operands.
    assign mul_start = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign mul_a     = r_op_a;
    assign mul_b     = r_op_b;

    // Result port.
    assign res_valid = (r_state == ST_DONE);
    assign res_a     = r_res_a;
    assign res_b     = r_res_b;
    assign res_p     = r_res_p;
    assign res_err   = r_res_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and job-control strobes; mul_flag matters only in IDLE
    // (a stale high flag holds off the next pop) and WAIT (completion).
    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_load_ok    = 1'b0;
        w_load_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty && !mul_flag) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                // A flag arriving on the last allowed cycle still counts as success.
                if (mul_flag) begin
                    w_load_ok    = 1'b1;
                    w_next_state = ST_DONE;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_load_err   = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Operand registers: loaded from the FIFO head on each pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a <= '0;
            r_op_b <= '0;
        end else if (w_pop) begin
            r_op_a <= w_fifo_out.a;
            r_op_b <= w_fifo_out.b;
        end
    end

    // Timeout counter: cleared in ISSUE, counts every cycle spent in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end

    // Result capture on leaving WAIT; held unchanged through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_a   <= '0;
            r_res_b   <= '0;
            r_res_p   <= '0;
            r_res_err <= 1'b0;
        end else if (w_load_ok) begin
            r_res_a   <= r_op_a;
            r_res_b   <= r_op_b;
            r_res_p   <= mul_p;
            r_res_err <= 1'b0;
        end else if (w_load_err) begin
            r_res_a   <= r_op_a;
            r_res_b   <= r_op_b;
            r_res_p   <= '0;
            r_res_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_shiftadd_seq.sv
// Scoreboard bench for shiftadd_seq with a behavioural shiftadd stand-in
// whose latency, lock-up and post-start flag hold are adjustable.
module tb_shiftadd_seq;
    import shiftadd_pkg::*;

    localparam int WIDTH   = DEF_WIDTH;
    localparam int DEPTH   = DEF_DEPTH;
    localparam int TIMEOUT = DEF_TIMEOUT;
    localparam int CW      = $clog2(DEPTH+1);

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [2*WIDTH-1:0] p;
        logic               err;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [CW-1:0]      fifo_count;
    logic               mul_start;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic               mul_flag;
    logic [2*WIDTH-1:0] mul_p;
    logic               res_valid;
    logic               res_ready;
    logic [WIDTH-1:0]   res_a;
    logic [WIDTH-1:0]   res_b;
    logic [2*WIDTH-1:0] res_p;
    logic               res_err;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    int   n_results = 0;
    int   peak = 0;

    int   stub_lat   = 3;
    bit   stub_dead  = 1'b0;
    int   stub_stale = 0;

    logic               st_flag;
    logic [2*WIDTH-1:0] st_p;
    int                 st_cnt;
    int                 st_hold;

    always #5 clk = ~clk;

    shiftadd_seq #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .fifo_count (fifo_count),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_flag   (mul_flag),
        .mul_p      (mul_p),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_a      (res_a),
        .res_b      (res_b),
        .res_p      (res_p),
        .res_err    (res_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [2*WIDTH-1:0] shift_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] acc;
        acc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) acc = acc + ({{WIDTH{1'b0}}, a} << i);
        end
        return acc;
    endfunction

    // Multiplier stand-in: flag rises stub_lat cycles into a start pulse and
    // stays up while start is high, then lingers stub_stale cycles after start drops.
    always @(posedge clk) begin
        if (rst) begin
            st_flag <= 1'b0;
            st_p    <= '0;
            st_cnt  <= 0;
            st_hold <= 0;
        end else if (mul_start) begin
            st_hold <= 0;
            if (!st_flag && !stub_dead) begin
                if (st_cnt == stub_lat) begin
                    st_flag <= 1'b1;
                    st_p    <= shift_add(mul_a, mul_b);
                end else begin
                    st_cnt <= st_cnt + 1;
                end
            end
        end else begin
            st_cnt <= 0;
            if (st_flag) begin
                if (st_hold >= stub_stale) begin
                    st_flag <= 1'b0;
                    st_hold <= 0;
                end else begin
                    st_hold <= st_hold + 1;
                end
            end
        end
    end

    assign mul_flag = st_flag;
    assign mul_p    = st_p;

    // Result monitor: compares each handshaken result with the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                check("res_a", res_a, e.a);
                check("res_b", res_b, e.b);
                check("res_p", res_p, e.p);
                check("res_err", res_err, e.err);
                check("start_low_in_done", mul_start, 0);
            end
            n_results++;
        end
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit exp_err);
        exp_t e;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        if (in_ready) begin
            e.a   = a;
            e.b   = b;
            e.p   = exp_err ? '0 : (2*WIDTH)'(a) * (2*WIDTH)'(b);
            e.err = exp_err;
            sb.push_back(e);
        end
        step();
        in_valid = 1'b0;
    endtask

    function automatic bit cond_met(input int which);
        case (which)
            0:       return mul_start;
            1:       return !mul_start;
            2:       return res_valid;
            default: return fifo_count == '0 && !res_valid && !mul_start && !mul_flag && sb.size() == 0;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int which);
        int n;
        n = 0;
        while (!cond_met(which) && n < 500) begin
            step();
            n++;
        end
        check(tag, cond_met(which), 1);
    endtask

    task automatic count_while(input bit level, output int n);
        n = 0;
        while (mul_start == level && n < 200) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int n0;
        int unstable;
        logic [WIDTH-1:0]   snap_a;
        logic [WIDTH-1:0]   snap_b;
        logic [2*WIDTH-1:0] snap_p;
        logic               snap_err;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b1;
        repeat (3) step();

        // Reset state.
        check("rst_in_ready", in_ready, 1);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_a", res_a, 0);
        check("rst_res_b", res_b, 0);
        check("rst_res_p", res_p, 0);
        check("rst_res_err", res_err, 0);
        rst = 1'b0;
        step();

        // Single job: start held from ISSUE through the flag cycle.
        push_one(4'd4, 4'd6, 1'b0);
        wait_for("single_start_rise", 0);
        check("single_mul_a", mul_a, 4);
        check("single_mul_b", mul_b, 6);
        count_while(1'b1, n);
        check("single_start_cycles", n, stub_lat + 2);
        wait_for("single_idle", 3);

        // Back-to-back burst; one pop overlaps the pushes.
        peak = 0;
        n0 = n_results;
        push_one(4'd15, 4'd15, 1'b0);
        push_one(4'd0,  4'd9,  1'b0);
        push_one(4'd3,  4'd5,  1'b0);
        push_one(4'd1,  4'd1,  1'b0);
        wait_for("burst_idle", 3);
        check("burst_peak_count", peak, 3);
        check("burst_results", n_results - n0, 4);

        // Full FIFO while a job sits in DONE.
        res_ready = 1'b0;
        n0 = n_results;
        push_one(4'd1, 4'd2, 1'b0);
        wait_for("full_stuck_done", 2);
        push_one(4'd3, 4'd4, 1'b0);
        push_one(4'd5, 4'd6, 1'b0);
        push_one(4'd7, 4'd8, 1'b0);
        push_one(4'd9, 4'd10, 1'b0);
        check("full_count", fifo_count, 4);
        check("full_in_ready", in_ready, 0);
        push_one(4'd11, 4'd12, 1'b0);
        check("full_push_ignored", fifo_count, 4);
        res_ready = 1'b1;
        wait_for("full_idle", 3);
        check("full_results", n_results - n0, 5);

        // Timeout with a multiplier that never answers, then a normal job.
        stub_dead = 1'b1;
        push_one(4'd7, 4'd3, 1'b1);
        wait_for("tmo_start_rise", 0);
        count_while(1'b1, n);
        check("tmo_start_cycles", n, TIMEOUT + 1);
        wait_for("tmo_idle", 3);
        stub_dead = 1'b0;
        push_one(4'd2, 4'd7, 1'b0);
        wait_for("tmo_next_idle", 3);

        // Flag on the last allowed WAIT cycle wins over the timeout.
        stub_lat = TIMEOUT - 1;
        push_one(4'd13, 4'd11, 1'b0);
        wait_for("edge_start_rise", 0);
        count_while(1'b1, n);
        check("edge_start_cycles", n, TIMEOUT + 1);
        wait_for("edge_idle", 3);
        stub_lat = 3;

        // Backpressure: result held stable while res_ready is low.
        res_ready = 1'b0;
        push_one(4'd9, 4'd7, 1'b0);
        wait_for("bp_valid", 2);
        snap_a   = res_a;
        snap_b   = res_b;
        snap_p   = res_p;
        snap_err = res_err;
        check("bp_res_p", snap_p, 63);
        unstable = 0;
        repeat (10) begin
            step();
            if (!res_valid || res_a !== snap_a || res_b !== snap_b ||
                res_p !== snap_p || res_err !== snap_err) unstable++;
        end
        check("bp_stable", unstable, 0);
        res_ready = 1'b1;
        wait_for("bp_idle", 3);

        // Lingering flag after start drops delays the next pop.
        for (int s = 0; s <= 2; s += 2) begin
            stub_stale = s;
            push_one(4'd2, 4'd3, 1'b0);
            push_one(4'd4, 4'd5, 1'b0);
            wait_for("stale_first_start", 0);
            wait_for("stale_first_end", 1);
            count_while(1'b0, n);
            check($sformatf("stale%0d_gap", s), n, 2 + s);
            wait_for("stale_idle", 3);
        end
        stub_stale = 0;

        // Reset in the middle of WAIT discards the job and the queue.
        stub_dead = 1'b1;
        push_one(4'd5, 4'd5, 1'b1);
        push_one(4'd6, 4'd6, 1'b1);
        wait_for("rstw_start_rise", 0);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        stub_dead = 1'b0;
        check("rstw_mul_start", mul_start, 0);
        check("rstw_res_valid", res_valid, 0);
        check("rstw_fifo_count", fifo_count, 0);
        check("rstw_in_ready", in_ready, 1);
        n0 = n_results;
        repeat (TIMEOUT + 10) step();
        check("rstw_no_result", n_results - n0, 0);
        check("rstw_quiet_start", mul_start, 0);
        push_one(4'd15, 4'd15, 1'b0);
        wait_for("rstw_next_idle", 3);

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
